// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
// Per-motor duty-ramp and protection sequencer. It takes a target duty and a
// ramp step from the SPI register decoder and slews the applied duty toward
// the target once per 1 us tick. Braking is sequenced as ramp-to-zero followed
// by a brake hold. A filtered driver fault forces a safe state.
//
// Optional feature macro: RAMP_FAULT_AUTORECOVER_EN
//   When it is defined, FAULT also returns to IDLE by itself once the
//   synchronized nfault has stayed high for FAULT_FILTER cycles. fault_sticky
//   stays set until a ctrl[0] write.
//
// Ports
//   clk_100m        in   system clock
//   rst_n_syn       in   synchronous active-low reset
//   data_mosi[31:0] in   SPI write data
//   data_mosi_rdy   in   one-cycle write strobe (data_mosi/addr valid)
//   addr[15:0]      in   SPI register address (8 target, 9 step, 10 ctrl)
//   nfault          in   raw driver fault, active-low, asynchronous
//   pwm_cycle[23:0] in   current PWM period, the duty ceiling
//   duty_out[23:0]  out  applied duty
//   brake_out       out  brake command (BRAKE and FAULT)
//   droff_out       out  driver-off command (FAULT)
//   ramp_busy       out  high in RAMP_UP / RAMP_DOWN
//   ramp_status_reg out  {state[2:0], fault_sticky, 4'b0, duty_out[23:0]}
// -----------------------------------------------------------------------------
module motor_ramp_ctrl (
    input  logic        clk_100m,
    input  logic        rst_n_syn,
    input  logic [31:0] data_mosi,
    input  logic        data_mosi_rdy,
    input  logic [15:0] addr,
    input  logic        nfault,
    input  logic [23:0] pwm_cycle,
    output logic [23:0] duty_out,
    output logic        brake_out,
    output logic        droff_out,
    output logic        ramp_busy,
    output logic [31:0] ramp_status_reg
);

    localparam logic [15:0] ADDR_RAMP_TARGET  = 16'd8;
    localparam logic [15:0] ADDR_RAMP_STEP    = 16'd9;
    localparam logic [15:0] ADDR_RAMP_CTRL    = 16'd10;
    localparam int          TICK_DIV          = 100;
    localparam logic [23:0] RAMP_STEP_DEFAULT = 24'd64;
    localparam int          FAULT_FILTER      = 8;

    localparam logic [6:0]  TICK_LAST   = 7'(TICK_DIV - 1);
    localparam logic [3:0]  FILTER_MAX  = 4'(FAULT_FILTER);
    localparam logic [3:0]  FILTER_LAST = 4'(FAULT_FILTER - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_BRAKE     = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] duty_q, duty_d;
    logic        brake_q, droff_q, busy_q;
    logic [23:0] target_q, target_d;
    logic        brk_req_q, brk_req_d;
    logic [23:0] step_q, step_d;
    logic [6:0]  tick_cnt_q, tick_cnt_d;
    logic        nf_meta_q, nf_sync_q;
    logic [3:0]  low_cnt_q, low_cnt_d;
    logic        sticky_q, sticky_d;
`ifdef RAMP_FAULT_AUTORECOVER_EN
    logic [3:0]  high_cnt_q, high_cnt_d;
`endif

    logic        wr_target, wr_step, wr_ctrl;
    logic        tick, fault_det, clear_ok;
    logic [23:0] eff;
    logic [24:0] eff_w, duty_w, step_w, stepped_w;
    logic [23:0] ramp_duty;
    logic        unused_bits;

    assign unused_bits = ^data_mosi[31:25];

    assign wr_target = data_mosi_rdy && (addr == ADDR_RAMP_TARGET);
    assign wr_step   = data_mosi_rdy && (addr == ADDR_RAMP_STEP);
    assign wr_ctrl   = data_mosi_rdy && (addr == ADDR_RAMP_CTRL);
    assign tick      = (tick_cnt_q == TICK_LAST);
    // The 8th consecutive low synchronized sample declares the fault.
    assign fault_det = !nf_sync_q && (low_cnt_q >= FILTER_LAST);
    // A clear is honoured only while the driver no longer reports a fault.
    assign clear_ok  = wr_ctrl && data_mosi[0] && nf_sync_q;

    // A pending brake request drives the effective target to zero.
    assign eff = brk_req_q ? 24'd0 : ((target_q < pwm_cycle) ? target_q : pwm_cycle);

    // One ramp step toward eff, in 25 bits so neither direction can wrap.
    // The step never passes eff; a zero step jumps straight to it.
    assign eff_w  = {1'b0, eff};
    assign duty_w = {1'b0, duty_q};
    assign step_w = {1'b0, step_q};
    always_comb begin
        stepped_w = eff_w;
        if (step_q != 24'd0) begin
            if (eff_w > duty_w) begin
                stepped_w = ((eff_w - duty_w) <= step_w) ? eff_w : (duty_w + step_w);
            end else begin
                stepped_w = ((duty_w - eff_w) <= step_w) ? eff_w : (duty_w - step_w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        target_d   = target_q;
        brk_req_d  = brk_req_q;
        step_d     = step_q;
        sticky_d   = sticky_q;
        ramp_duty  = tick ? stepped_w[23:0] : duty_q;
        tick_cnt_d = tick ? 7'd0 : (tick_cnt_q + 7'd1);
        low_cnt_d  = nf_sync_q ? 4'd0 :
                     ((low_cnt_q == FILTER_MAX) ? low_cnt_q : (low_cnt_q + 4'd1));
`ifdef RAMP_FAULT_AUTORECOVER_EN
        high_cnt_d = ((state_q == ST_FAULT) && nf_sync_q) ?
                     ((high_cnt_q == FILTER_MAX) ? high_cnt_q : (high_cnt_q + 4'd1)) : 4'd0;
`endif

        if (wr_target) begin
            target_d  = data_mosi[23:0];
            brk_req_d = data_mosi[24];
        end
        if (wr_step) begin
            step_d = data_mosi[23:0];
        end
        if (clear_ok) begin
            sticky_d = 1'b0;
        end

        if (fault_det) begin
            state_d  = ST_FAULT;
            duty_d   = 24'd0;
            sticky_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (brk_req_q)          state_d = ST_RAMP_DOWN;
                    else if (eff > duty_q)  state_d = ST_RAMP_UP;
                    else if (eff < duty_q)  state_d = ST_RAMP_DOWN;
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    // Direction is re-derived every cycle from the current
                    // duty, so a retarget mid-ramp cannot overshoot.
                    duty_d = ramp_duty;
                    if (ramp_duty == eff)      state_d = brk_req_q ? ST_BRAKE : ST_IDLE;
                    else if (eff > ramp_duty)  state_d = ST_RAMP_UP;
                    else                       state_d = ST_RAMP_DOWN;
                end
                ST_BRAKE: begin
                    duty_d = 24'd0;
                    // Releases on the write edge itself, not a cycle later.
                    if (wr_target && !data_mosi[24]) state_d = ST_IDLE;
                end
                ST_FAULT: begin
                    duty_d = 24'd0;
                    if (clear_ok) begin
                        state_d   = ST_IDLE;
                        target_d  = 24'd0;
                        brk_req_d = 1'b0;
                    end
`ifdef RAMP_FAULT_AUTORECOVER_EN
                    else if (nf_sync_q && (high_cnt_q >= FILTER_LAST)) begin
                        state_d   = ST_IDLE;
                        target_d  = 24'd0;
                        brk_req_d = 1'b0;
                    end
`endif
                end
                default: begin
                    state_d = ST_FAULT;
                    duty_d  = 24'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!rst_n_syn) begin
            state_q    <= ST_IDLE;
            duty_q     <= 24'd0;
            brake_q    <= 1'b0;
            droff_q    <= 1'b0;
            busy_q     <= 1'b0;
            target_q   <= 24'd0;
            brk_req_q  <= 1'b0;
            step_q     <= RAMP_STEP_DEFAULT;
            tick_cnt_q <= 7'd0;
            nf_meta_q  <= 1'b1;
            nf_sync_q  <= 1'b1;
            low_cnt_q  <= 4'd0;
            sticky_q   <= 1'b0;
`ifdef RAMP_FAULT_AUTORECOVER_EN
            high_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            brake_q    <= (state_d == ST_BRAKE) || (state_d == ST_FAULT);
            droff_q    <= (state_d == ST_FAULT);
            busy_q     <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
            target_q   <= target_d;
            brk_req_q  <= brk_req_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            nf_meta_q  <= nfault;
            nf_sync_q  <= nf_meta_q;
            low_cnt_q  <= low_cnt_d;
            sticky_q   <= sticky_d;
`ifdef RAMP_FAULT_AUTORECOVER_EN
            high_cnt_q <= high_cnt_d;
`endif
        end
    end

    assign duty_out        = duty_q;
    assign brake_out       = brake_q;
    assign droff_out       = droff_q;
    assign ramp_busy       = busy_q;
    assign ramp_status_reg = {state_q, sticky_q, 4'b0000, duty_q};

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_motor_ramp_ctrl
// Directed bench for motor_ramp_ctrl. A behavioural model tracks the expected
// outputs every cycle; a change log of duty_out is checked against
// hand-computed duty sequences and tick spacing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_motor_ramp_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        rdy;
    logic [15:0] addr;
    logic        nfault;
    logic [23:0] pwm;
    logic [23:0] duty_out;
    logic        brake_out;
    logic        droff_out;
    logic        ramp_busy;
    logic [31:0] status;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    motor_ramp_ctrl dut (
        .clk_100m        (clk),
        .rst_n_syn       (rst_n),
        .data_mosi       (data),
        .data_mosi_rdy   (rdy),
        .addr            (addr),
        .nfault          (nfault),
        .pwm_cycle       (pwm),
        .duty_out        (duty_out),
        .brake_out       (brake_out),
        .droff_out       (droff_out),
        .ramp_busy       (ramp_busy),
        .ramp_status_reg (status)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 up, 2 down, 3 brake, 4 fault.
    int m_state, m_duty, m_tgt, m_brk, m_step, m_tick;
    int m_nf1, m_nf2, m_low, m_high, m_sticky;
    int m_brake_o, m_droff_o, m_busy;

    function automatic int approach(input int d, input int e, input int s);
        if (s == 0) return e;
        if (e > d) return ((e - d) <= s) ? e : d + s;
        return ((d - e) <= s) ? e : d - s;
    endfunction

    always @(posedge clk) begin : model
        int eff, nd, ns;
        bit tk, flt, clr, wr_t, wr_s, wr_c;
        if (!rst_n) begin
            m_state = 0; m_duty = 0; m_tgt = 0; m_brk = 0; m_step = 64; m_tick = 0;
            m_nf1 = 1; m_nf2 = 1; m_low = 0; m_high = 0; m_sticky = 0;
            m_brake_o = 0; m_droff_o = 0; m_busy = 0;
        end else begin
            wr_t = rdy && (addr == 16'd8);
            wr_s = rdy && (addr == 16'd9);
            wr_c = rdy && (addr == 16'd10) && data[0];
            tk   = (m_tick == 99);
            flt  = (m_nf2 == 0) && (m_low >= 7);
            clr  = wr_c && (m_nf2 == 1);
            eff  = m_brk ? 0 : ((m_tgt < int'(pwm)) ? m_tgt : int'(pwm));
            ns = m_state;
            nd = m_duty;
            if (flt) begin
                ns = 4; nd = 0;
            end else if (m_state == 4) begin
                nd = 0;
                if (clr) ns = 0;
`ifdef RAMP_FAULT_AUTORECOVER_EN
                else if (m_nf2 == 1 && m_high >= 7) ns = 0;
`endif
            end else if (m_state == 3) begin
                nd = 0;
                if (wr_t && !data[24]) ns = 0;
            end else if (m_state == 0) begin
                ns = m_brk ? 2 : (eff > nd) ? 1 : (eff < nd) ? 2 : 0;
            end else begin
                if (tk) nd = approach(m_duty, eff, m_step);
                ns = (nd == eff) ? (m_brk ? 3 : 0) : ((eff > nd) ? 1 : 2);
            end
            if (wr_t) begin m_tgt = int'(data[23:0]); m_brk = int'(data[24]); end
            if (wr_s) m_step = int'(data[23:0]);
            if (m_state == 4 && ns == 0) begin m_tgt = 0; m_brk = 0; end
            if (clr) m_sticky = 0;
            if (flt) m_sticky = 1;
            m_high = (m_state == 4 && m_nf2 == 1) ? ((m_high < 8) ? m_high + 1 : 8) : 0;
            m_low  = (m_nf2 == 0) ? ((m_low < 8) ? m_low + 1 : 8) : 0;
            m_nf2  = m_nf1;
            m_nf1  = int'(nfault);
            m_tick = tk ? 0 : m_tick + 1;
            m_state = ns;
            m_duty  = nd;
            m_brake_o = (ns == 3 || ns == 4) ? 1 : 0;
            m_droff_o = (ns == 4) ? 1 : 0;
            m_busy    = (ns == 1 || ns == 2) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_duty",   duty_out,  m_duty);
            check("m_brake",  brake_out, m_brake_o);
            check("m_droff",  droff_out, m_droff_o);
            check("m_busy",   ramp_busy, m_busy);
            check("m_status", status,    {m_state[2:0], m_sticky[0], 4'b0000, m_duty[23:0]});
        end
    end

    // ---------------- duty change log ----------------
    logic [23:0] prev_duty = 24'd0;
    int          cyc = 0;
    logic [23:0] chg_val[$];
    int          chg_cyc[$];
    logic [23:0] exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (duty_out !== prev_duty) begin
            chg_val.push_back(duty_out);
            chg_cyc.push_back(cyc);
            prev_duty = duty_out;
        end
    end

    task automatic clear_log();
        chg_val.delete();
        chg_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_changes(input string name, input bit spaced);
        check({name, "_count"}, chg_val.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < chg_val.size(); i++) begin
            check($sformatf("%s_val%0d", name, i), chg_val[i], exp_q[i]);
            if (spaced && i > 0)
                check($sformatf("%s_gap%0d", name, i), chg_cyc[i] - chg_cyc[i-1], 100);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 2 ns after a rising edge; callers stay in that phase.
    task automatic spi_write(input logic [15:0] a, input logic [31:0] d);
        addr = a; data = d; rdy = 1'b1;
        @(posedge clk); #2;
        rdy = 1'b0; addr = 16'd0; data = 32'd0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic to_phase();
        @(posedge clk); #2;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int lat;
        bit found;
        rst_n = 1'b0; data = 32'd0; rdy = 1'b0; addr = 16'd0; nfault = 1'b1; pwm = 24'd5000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_duty",   duty_out, 0);
        check("rst_brake",  brake_out, 0);
        check("rst_droff",  droff_out, 0);
        check("rst_busy",   ramp_busy, 0);
        check("rst_status", status, 0);
        cmp_en = 1;
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Ramp up 0 -> 1000 in steps of 100.
        clear_log();
        spi_write(16'd9, 32'd100);
        spi_write(16'd8, 32'd1000);
        wait_cycles(1100);
        for (int v = 100; v <= 1000; v += 100) exp_q.push_back(24'(v));
        check_changes("ramp_up", 1'b1);
        @(negedge clk);
        check("up_end_state", status[31:29], 0);
        check("up_end_busy",  ramp_busy, 0);
        to_phase();

        // Ramp down 1000 -> 250 with step 300, no undershoot.
        clear_log();
        spi_write(16'd9, 32'd300);
        spi_write(16'd8, 32'd250);
        wait_cycles(400);
        exp_q = '{24'd700, 24'd400, 24'd250};
        check_changes("ramp_down", 1'b1);

        // Clamp to pwm_cycle, then follow a pwm_cycle drop.
        clear_log();
        spi_write(16'd9, 32'd1000);
        spi_write(16'd8, 32'd9000);
        wait_cycles(800);
        exp_q = '{24'd1250, 24'd2250, 24'd3250, 24'd4250, 24'd5000};
        check_changes("clamp", 1'b1);
        @(negedge clk);
        check("clamp_hold", duty_out, 5000);
        to_phase();
        clear_log();
        pwm = 24'd3000;
        wait_cycles(300);
        exp_q = '{24'd4000, 24'd3000};
        check_changes("pwm_drop", 1'b1);

        // Down to 600, then brake sequence and release.
        clear_log();
        spi_write(16'd8, 32'd600);
        pwm = 24'd5000;
        wait_cycles(400);
        exp_q = '{24'd2000, 24'd1000, 24'd600};
        check_changes("to600", 1'b1);
        clear_log();
        spi_write(16'd9, 32'd300);
        spi_write(16'd8, 32'h0100_0000);
        wait_cycles(300);
        exp_q = '{24'd300, 24'd0};
        check_changes("brake_ramp", 1'b1);
        @(negedge clk);
        check("brake_on",    brake_out, 1);
        check("brake_state", status[31:29], 3);
        to_phase();
        clear_log();
        spi_write(16'd8, 32'd500);
        @(negedge clk);
        check("brake_release", brake_out, 0);
        check("release_state", status[31:29], 0);
        to_phase();
        wait_cycles(300);
        exp_q = '{24'd300, 24'd500};
        check_changes("after_brake", 1'b1);

        // 7-cycle nfault glitch must be filtered out.
        nfault = 1'b0;
        repeat (7) @(posedge clk);
        #2 nfault = 1'b1;
        wait_cycles(20);
        @(negedge clk);
        check("glitch_droff", droff_out, 0);
        check("glitch_duty",  duty_out, 500);
        to_phase();

        // Real fault mid-ramp.
        spi_write(16'd9, 32'd100);
        spi_write(16'd8, 32'd4000);
        wait_cycles(50);
        nfault = 1'b0;
        lat = 0;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (duty_out == 24'd0 && droff_out && brake_out) begin
                lat = i;
                found = 1;
                break;
            end
        end
        check("fault_latency_le_11", (found && lat <= 11) ? 1 : 0, 1);
        check("fault_state_sticky", status[31:28], 4'b1001);
        to_phase();
        spi_write(16'd10, 32'd1);
        wait_cycles(3);
        @(negedge clk);
        check("clear_low_state", status[31:29], 4);
        check("clear_low_droff", droff_out, 1);
        to_phase();
        nfault = 1'b1;
        wait_cycles(5);
        spi_write(16'd10, 32'd1);
        @(negedge clk);
        check("clear_state", status, 0);
        check("clear_brake", brake_out, 0);
        check("clear_droff", droff_out, 0);
        to_phase();
        wait_cycles(250);
        @(negedge clk);
        check("clear_target_zero", duty_out, 0);
        to_phase();

        // Reset mid-ramp, then default step of 64.
        spi_write(16'd9, 32'd100);
        spi_write(16'd8, 32'd3000);
        wait_cycles(250);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_duty",   duty_out, 0);
        check("midrst_brake",  brake_out, 0);
        check("midrst_droff",  droff_out, 0);
        check("midrst_busy",   ramp_busy, 0);
        check("midrst_status", status, 0);
        to_phase();
        rst_n = 1'b1;
        clear_log();
        spi_write(16'd8, 32'd640);
        wait_cycles(1100);
        for (int v = 64; v <= 640; v += 64) exp_q.push_back(24'(v));
        check_changes("default_step", 1'b1);

        // Step 0 jumps straight to the target on the first tick.
        clear_log();
        spi_write(16'd9, 32'd0);
        spi_write(16'd8, 32'd777);
        wait_cycles(150);
        exp_q = '{24'd777};
        check_changes("step0", 1'b0);

        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
